// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack port, lane steering, load extension, pipe/debug arbitration.
// Optional ack watchdog with o_err output when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned MEM_AW = 10
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_memread,
  input  logic              i_memwrite,
  input  logic [NBITS-1:0]  i_aluresult,
  input  logic [NBITS-1:0]  i_wrdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_stall,
  output logic [NBITS-1:0]  o_memstgdata,
  output logic              o_misalign,
  input  logic              i_dbg_req,
  input  logic [MEM_AW-1:0] i_dbg_addr,
  output logic              o_dbg_gnt,
  output logic              o_dbg_valid,
  output logic [NBITS-1:0]  o_dbg_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [NBITS-1:0]  o_mem_wdata,
  output logic [3:0]        o_mem_be,
`ifdef MEM_TIMEOUT_EN
  output logic              o_err,
`endif
  input  logic              i_mem_ack,
  input  logic [NBITS-1:0]  i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PIPE  = 3'd1,
    S_DBG   = 3'd2,
    S_PDONE = 3'd3,
    S_DDONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [NBITS-1:0]  r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic              r_dbg_gnt;
  logic              r_dbg_valid;
  logic [NBITS-1:0]  r_dbg_data;
  logic [NBITS-1:0]  r_load_q;
  logic              r_last_pipe;

  logic              w_pipe_acc;
  logic              w_misal;
  logic              w_pipe_ok;
  logic              w_dbg_win;
  logic              w_issue_pipe;
  logic              w_issue_dbg;
  logic              w_timeout;
  logic              w_pipe_end;
  logic              w_dbg_end;
  logic [3:0]        w_be;
  logic [NBITS-1:0]  w_wdata;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [NBITS-1:0]  w_ld_ext;

  // Access classification from the (stall-frozen) pipeline inputs
  assign w_pipe_acc = i_memread | i_memwrite;
  assign w_misal    = ((i_size == 2'b01) && i_aluresult[0]) ||
                      (i_size[1] && (i_aluresult[1:0] != 2'b00));
  assign w_pipe_ok  = w_pipe_acc && !w_misal;
  assign w_dbg_win  = i_dbg_req && (!w_pipe_ok || r_last_pipe);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !i_mem_ack;
  assign o_err     = r_err;

  // Watchdog counts req cycles of the current access
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= (r_state inside {S_PIPE, S_DBG}) && w_timeout;
      if (w_issue_pipe || w_issue_dbg) begin
        r_to_cnt <= '0;
      end else if (r_state inside {S_PIPE, S_DBG}) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_pipe_end = (r_state == S_PIPE) && (i_mem_ack || w_timeout);
  assign w_dbg_end  = (r_state == S_DBG)  && (i_mem_ack || w_timeout);

  // Store lane steering and load extraction/extension
  always_comb begin
    w_be      = 4'hF;
    w_wdata   = i_wrdata;
    w_ld_byte = i_mem_rdata[{i_aluresult[1:0], 3'b000} +: 8];
    w_ld_half = i_mem_rdata[{i_aluresult[1], 4'b0000} +: 16];
    w_ld_ext  = i_mem_rdata;
    unique case (i_size)
      2'b00: begin
        w_be     = 4'b0001 << i_aluresult[1:0];
        w_wdata  = {4{i_wrdata[7:0]}};
        w_ld_ext = i_unsigned ? {{(NBITS-8){1'b0}}, w_ld_byte}
                              : {{(NBITS-8){w_ld_byte[7]}}, w_ld_byte};
      end
      2'b01: begin
        w_be     = 4'b0011 << {i_aluresult[1], 1'b0};
        w_wdata  = {2{i_wrdata[15:0]}};
        w_ld_ext = i_unsigned ? {{(NBITS-16){1'b0}}, w_ld_half}
                              : {{(NBITS-16){w_ld_half[15]}}, w_ld_half};
      end
      default: begin
        w_be     = 4'hF;
        w_wdata  = i_wrdata;
        w_ld_ext = i_mem_rdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, arbitration and combinational pipeline-facing outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_issue_pipe = 1'b0;
    w_issue_dbg  = 1'b0;
    o_stall      = 1'b0;
    o_misalign   = 1'b0;
    o_memstgdata = i_aluresult;

    unique case (r_state)
      S_IDLE: begin
        if (w_dbg_win) begin
          w_issue_dbg = 1'b1;
          w_state_nxt = S_DBG;
        end else if (w_pipe_ok) begin
          w_issue_pipe = 1'b1;
          w_state_nxt  = S_PIPE;
        end
      end
      S_PIPE:  if (w_pipe_end) w_state_nxt = S_PDONE;
      S_DBG:   if (w_dbg_end)  w_state_nxt = S_DDONE;
      S_PDONE: w_state_nxt = S_IDLE;
      S_DDONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // PIPE/PDONE always hold the already-accepted aligned access
    o_stall    = i_rst_n && w_pipe_ok && (r_state != S_PDONE);
    o_misalign = i_rst_n && w_pipe_acc && w_misal &&
                 (r_state inside {S_IDLE, S_DBG, S_DDONE});
    if ((r_state == S_PDONE) && i_memread) begin
      o_memstgdata = r_load_q;
    end
  end

  // Registered memory-port and debug outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'h0;
      r_dbg_gnt   <= 1'b0;
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
      r_load_q    <= '0;
      r_last_pipe <= 1'b0;
    end else begin
      r_dbg_gnt   <= w_issue_dbg;
      r_dbg_valid <= w_dbg_end;
      if (w_issue_pipe) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= i_memwrite;
        r_mem_addr  <= i_aluresult[MEM_AW+1:2];
        r_mem_wdata <= i_memwrite ? w_wdata : '0;
        r_mem_be    <= w_be;
        r_last_pipe <= 1'b1;
      end else if (w_issue_dbg) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= i_dbg_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= 4'hF;
        r_last_pipe <= 1'b0;
      end
      if (w_pipe_end) begin
        r_mem_req <= 1'b0;
        r_load_q  <= i_mem_ack ? w_ld_ext : '0;
      end
      if (w_dbg_end) begin
        r_mem_req  <= 1'b0;
        r_dbg_data <= i_mem_ack ? i_mem_rdata : '0;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_dbg_gnt   = r_dbg_gnt;
  assign o_dbg_valid = r_dbg_valid;
  assign o_dbg_data  = r_dbg_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the memory port ack/rdata is driven by hand.
module tb_mem_access_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_memread;
  logic        i_memwrite;
  logic [31:0] i_aluresult;
  logic [31:0] i_wrdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_stall;
  logic [31:0] o_memstgdata;
  logic        o_misalign;
  logic        i_dbg_req;
  logic [9:0]  i_dbg_addr;
  logic        o_dbg_gnt;
  logic        o_dbg_valid;
  logic [31:0] o_dbg_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
`ifdef MEM_TIMEOUT_EN
  logic        o_err;
`endif

  int          n_checks;
  int          n_errors;
  int          cap_stalls;
  logic        cap_req;
  logic        cap_we;
  logic [9:0]  cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  mem_access_ctrl u_dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_memread    (i_memread),
    .i_memwrite   (i_memwrite),
    .i_aluresult  (i_aluresult),
    .i_wrdata     (i_wrdata),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .o_stall      (o_stall),
    .o_memstgdata (o_memstgdata),
    .o_misalign   (o_misalign),
    .i_dbg_req    (i_dbg_req),
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_gnt    (o_dbg_gnt),
    .o_dbg_valid  (o_dbg_valid),
    .o_dbg_data   (o_dbg_data),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
`ifdef MEM_TIMEOUT_EN
    .o_err        (o_err),
`endif
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_pipe(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    i_memread   = rd;
    i_memwrite  = wr;
    i_size      = sz;
    i_unsigned  = uns;
    i_aluresult = addr;
    i_wrdata    = wd;
    #1;
  endtask

  // From IDLE with an aligned access applied: w req cycles without ack, then ack; ends in PDONE
  task automatic pipe_access(input int w, input logic [31:0] rd);
    cap_stalls = 0;
    if (o_stall) cap_stalls++;
    tick();
    cap_req   = o_mem_req;
    cap_we    = o_mem_we;
    cap_addr  = o_mem_addr;
    cap_be    = o_mem_be;
    cap_wdata = o_mem_wdata;
    for (int k = 0; k < w; k++) begin
      if (o_stall) cap_stalls++;
      tick();
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = rd;
    #1;
    if (o_stall) cap_stalls++;
    tick();
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
  endtask

  // Leave PDONE: the pipeline advances and the request is withdrawn
  task automatic end_pipe();
    tick();
    i_memread  = 1'b0;
    i_memwrite = 1'b0;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    i_rst_n     = 1'b0;
    i_memread   = 1'b0;
    i_memwrite  = 1'b0;
    i_aluresult = 32'h0000_1234;
    i_wrdata    = 32'h0;
    i_size      = 2'b10;
    i_unsigned  = 1'b0;
    i_dbg_req   = 1'b0;
    i_dbg_addr  = 10'h0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_req",    32'(o_mem_req),   32'h0);
    chk("rst_stall",  32'(o_stall),     32'h0);
    chk("rst_gnt",    32'(o_dbg_gnt),   32'h0);
    chk("rst_valid",  32'(o_dbg_valid), 32'h0);
    chk("rst_dbgdat", o_dbg_data,       32'h0);
    chk("rst_memstg", o_memstgdata,     32'h0000_1234);
    i_rst_n = 1'b1;
    tick();

    // Word load, three req cycles without ack then ack -> 5 stall cycles
    set_pipe(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    chk("t1_stall_comb", 32'(o_stall), 32'h1);
    pipe_access(3, 32'hDEAD_BEEF);
    chk("t1_stall_cyc", 32'(cap_stalls), 32'd5);
    chk("t1_req",       32'(cap_req),    32'h1);
    chk("t1_we",        32'(cap_we),     32'h0);
    chk("t1_addr",      32'(cap_addr),   32'd2);
    chk("t1_data",      o_memstgdata,    32'hDEAD_BEEF);
    chk("t1_pd_stall",  32'(o_stall),    32'h0);
    chk("t1_req_drop",  32'(o_mem_req),  32'h0);
    end_pipe();
    chk("t1_idle_pass", o_memstgdata, 32'h08);

    // Byte load lane 3, signed, ack in first req cycle
    set_pipe(1'b1, 1'b0, 2'b00, 1'b0, 32'h03, 32'h0);
    pipe_access(0, 32'h80FF_0000);
    chk("t2_stall_cyc", 32'(cap_stalls), 32'd2);
    chk("t2_sbyte",     o_memstgdata,    32'hFFFF_FF80);
    end_pipe();
    set_pipe(1'b1, 1'b0, 2'b00, 1'b1, 32'h03, 32'h0);
    pipe_access(1, 32'h80FF_0000);
    chk("t2u_stall_cyc", 32'(cap_stalls), 32'd3);
    chk("t2_ubyte",      o_memstgdata,    32'h0000_0080);
    end_pipe();
    set_pipe(1'b1, 1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
    pipe_access(0, 32'h8001_7FFF);
    chk("t2_shalf", o_memstgdata, 32'hFFFF_8001);
    end_pipe();

    // Half store upper lanes; byte store lane 1
    set_pipe(1'b0, 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_ABCD);
    pipe_access(2, 32'h0);
    chk("t3_we",     32'(cap_we),    32'h1);
    chk("t3_be",     32'(cap_be),    32'hC);
    chk("t3_wdata",  cap_wdata,      32'hABCD_ABCD);
    chk("t3_addr",   32'(cap_addr),  32'd1);
    chk("t3_memstg", o_memstgdata,   32'h06);
    end_pipe();
    set_pipe(1'b0, 1'b1, 2'b00, 1'b0, 32'h01, 32'h1234_565A);
    pipe_access(0, 32'h0);
    chk("t3b_be",    32'(cap_be), 32'h2);
    chk("t3b_wdata", cap_wdata,   32'h5A5A_5A5A);
    end_pipe();

    // Misaligned word load and half store are suppressed
    set_pipe(1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    chk("t4_misal",  32'(o_misalign), 32'h1);
    chk("t4_stall",  32'(o_stall),    32'h0);
    chk("t4_memstg", o_memstgdata,    32'h02);
    tick();
    chk("t4_noreq",  32'(o_mem_req),  32'h0);
    set_pipe(1'b0, 1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF);
    chk("t4_misal_h", 32'(o_misalign), 32'h1);
    tick();
    chk("t4_noreq_h", 32'(o_mem_req),  32'h0);
    set_pipe(1'b0, 1'b0, 2'b10, 1'b0, 32'h05, 32'h0);
    chk("t4_misal_off", 32'(o_misalign), 32'h0);

    // Debug request during a pipe load, then a back-to-back pipe load
    set_pipe(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    i_dbg_req  = 1'b1;
    i_dbg_addr = 10'h055;
    tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h1111_1111;
    tick();
    i_mem_ack = 1'b0;
    chk("t5_pdata",   o_memstgdata,   32'h1111_1111);
    chk("t5_nogntpd", 32'(o_dbg_gnt), 32'h0);
    tick();
    i_aluresult = 32'h14;
    #1;
    chk("t5_heldoff", 32'(o_stall), 32'h1);
    tick();
    chk("t5_gnt",     32'(o_dbg_gnt),  32'h1);
    chk("t5_dreq",    32'(o_mem_req),  32'h1);
    chk("t5_dwe",     32'(o_mem_we),   32'h0);
    chk("t5_dbe",     32'(o_mem_be),   32'hF);
    chk("t5_daddr",   32'(o_mem_addr), 32'h055);
    chk("t5_dstall",  32'(o_stall),    32'h1);
    i_dbg_req   = 1'b0;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    tick();
    i_mem_ack = 1'b0;
    chk("t5_dvalid",  32'(o_dbg_valid), 32'h1);
    chk("t5_ddata",   o_dbg_data,       32'hCAFE_F00D);
    chk("t5_gnt_off", 32'(o_dbg_gnt),   32'h0);
    chk("t5_ddstall", 32'(o_stall),     32'h1);
    chk("t5_ddreq",   32'(o_mem_req),   32'h0);
    tick();
    chk("t5_vld_off", 32'(o_dbg_valid), 32'h0);
    chk("t5_istall",  32'(o_stall),     32'h1);
    tick();
    chk("t5_p2req",   32'(o_mem_req),  32'h1);
    chk("t5_p2addr",  32'(o_mem_addr), 32'd5);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h2222_2222;
    tick();
    i_mem_ack = 1'b0;
    chk("t5_p2data",  o_memstgdata,    32'h2222_2222);
    chk("t5_p2stall", 32'(o_stall),    32'h0);
    chk("t5_dhold",   o_dbg_data,      32'hCAFE_F00D);
    end_pipe();

    // Reset in the middle of a pipe access
    set_pipe(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    tick();
    chk("t6_req_on", 32'(o_mem_req), 32'h1);
    i_rst_n = 1'b0;
    tick();
    chk("t6_rst_req",   32'(o_mem_req), 32'h0);
    chk("t6_rst_stall", 32'(o_stall),   32'h0);
    i_rst_n   = 1'b1;
    i_memread = 1'b0;
    tick();
    chk("t6_post_req", 32'(o_mem_req), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No ack: watchdog ends the access after 16 req cycles with zero data
    set_pipe(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    tick();
    repeat (15) tick();
    chk("t7_err_early", 32'(o_err),     32'h0);
    chk("t7_req_16",    32'(o_mem_req), 32'h1);
    tick();
    chk("t7_err",       32'(o_err),     32'h1);
    chk("t7_data0",     o_memstgdata,   32'h0);
    chk("t7_req_drop",  32'(o_mem_req), 32'h0);
    end_pipe();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
